// File: rtl/multicycle_control_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control path (opcodes, ALUOp, mux selects, FSM states).
// Latency: none (definitions only).
// Backpressure: n/a.
package multicycle_control_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ALUOp codes, also decoded by the ALU control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PCSource select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUSrcB select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        EXEC      = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        HALT      = 4'd12
    } state_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Purpose: counts consecutive memory-wait cycles, flags timeout and holds a sticky fault flag.
// Latency: timeout is combinational in the cycle the limit is reached; mem_fault registers one cycle later.
// Backpressure: none; a mem_ready in the limit cycle suppresses the timeout.
// Ports: clk, reset (sync, active-high), waiting (FSM is in a memory-wait state),
//        mem_ready, timeout (to FSM next-state), mem_fault (sticky until reset).
module multicycle_control_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout,
    output logic mem_fault
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic ENABLE = (MEM_TIMEOUT != 0);

    // cnt holds the number of earlier stalled cycles in the current wait state,
    // so the current stalled cycle is the LIMIT+1'th when cnt == LIMIT.
    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall   = waiting && !mem_ready;
    assign timeout = ENABLE && stall && (cnt == CNT_W'(LIMIT));

    // Every wait state exits on mem_ready, so clearing whenever not stalled
    // also covers clearing on state exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            mem_fault <= 1'b0;
        end else begin
            if (ENABLE && stall && !timeout)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (timeout)
                mem_fault <= 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: main control FSM of the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Latency: beq/j 3 cycles, R/addi/sw 4, lw 5 with MemReady tied high.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until MemReady; MEM_TIMEOUT stalled cycles -> HALT.
// Ports: clk, reset (sync, active-high), Op (IR[31:26]), MemReady; datapath enables/selects,
//        ALUOp to ALU control, IllegalOp (1-cycle pulse), MemFault (sticky), State (debug).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               IllegalOp,
    output logic               MemFault,
    output logic [STATE_W-1:0] State
);

    state_t state, next;
    logic   waiting;
    logic   timeout;
    logic   illegal_d;

    assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign State   = STATE_W'(state);

    multicycle_control_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .waiting   (waiting),
        .mem_ready (MemReady),
        .timeout   (timeout),
        .mem_fault (MemFault)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            IllegalOp <= 1'b0;
        end else begin
            state     <= next;
            IllegalOp <= illegal_d;
        end
    end

    always_comb begin
        next        = state;
        illegal_d   = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;

        case (state)
            FETCH: begin
                // PC+4 is computed every fetch cycle but only committed with the IR load.
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady)
                    next = DECODE;
            end
            DECODE: begin
                // Speculative branch target into ALUOut.
                ALUSrcB   = SRCB_IMM_SH2;
                illegal_d = !op_supported(Op);
                case (Op)
                    OP_R:         next = EXEC;
                    OP_LW, OP_SW: next = MEM_ADDR;
                    OP_BEQ:       next = BRANCH;
                    OP_J:         next = JUMP;
                    OP_ADDI:      next = ADDI_EXEC;
                    default:      next = FETCH;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = (Op == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)
                    next = MEM_WB;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                next     = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady)
                    next = FETCH;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                next    = R_WB;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                next     = FETCH;
            end
            ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                next        = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                next     = FETCH;
            end
            HALT:    next = HALT;
            default: next = FETCH;
        endcase

        // Timer only fires in a wait state with MemReady low, so it never
        // overrides a completing memory access.
        if (timeout)
            next = HALT;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: self-checking bench for multicycle_control against a path-list reference model.
// Latency: checks every cycle, inputs driven 1 time unit after the rising edge, sampled 2 units later.
// Backpressure: MemReady stalls and timeouts exercised with MEM_TIMEOUT=3.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int TIMEOUT = 3;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, IllegalOp, MemFault;
    logic [3:0] State;

    multicycle_control #(.MEM_TIMEOUT(TIMEOUT), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .IllegalOp(IllegalOp), .MemFault(MemFault),
        .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
        logic [1:0] pcsource, aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regwrite, regdst;
    } ctl_t;

    int     vectors;
    int     miscompares;

    // Reference model: current step plus the remaining steps of the instruction.
    state_t m_state;
    state_t m_path[$];
    int     m_wait;
    logic   m_fault;
    logic   m_ill;

    // Control values the datapath needs in each step, straight from the step table.
    function automatic ctl_t expect_ctl(input state_t s, input logic rdy);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:     begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
            DECODE:    c.alusrcb = 2'b11;
            MEM_ADDR,
            ADDI_EXEC: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            MEM_RD:    begin c.memread = 1; c.iord = 1; end
            MEM_WB:    begin c.regwrite = 1; c.memtoreg = 1; end
            MEM_WR:    begin c.memwrite = 1; c.iord = 1; end
            EXEC:      begin c.alusrca = 1; c.aluop = 2'b10; end
            R_WB:      begin c.regwrite = 1; c.regdst = 1; end
            ADDI_WB:   c.regwrite = 1;
            BRANCH:    begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
            JUMP:      begin c.pcwrite = 1; c.pcsource = 2'b10; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    task automatic model_clock(input logic rst, input logic [5:0] op, input logic rdy);
        if (rst) begin
            m_state = FETCH; m_wait = 0; m_fault = 0; m_ill = 0;
            m_path.delete();
            return;
        end
        m_ill = (m_state == DECODE) &&
                !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
        if ((m_state inside {FETCH, MEM_RD, MEM_WR}) && !rdy) begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
                m_state = HALT; m_fault = 1; m_wait = 0;
                m_path.delete();
            end
            return;
        end
        m_wait = 0;
        if (m_state == HALT) return;
        if (m_state == FETCH) begin
            m_state = DECODE;
            return;
        end
        if (m_state == DECODE) begin
            m_path.delete();
            case (op)
                OP_LW:   m_path = '{MEM_ADDR, MEM_RD, MEM_WB};
                OP_SW:   m_path = '{MEM_ADDR, MEM_WR};
                OP_R:    m_path = '{EXEC, R_WB};
                OP_ADDI: m_path = '{ADDI_EXEC, ADDI_WB};
                OP_BEQ:  m_path = '{BRANCH};
                OP_J:    m_path = '{JUMP};
                default: m_path.delete();
            endcase
        end
        m_state = (m_path.size() > 0) ? m_path.pop_front() : FETCH;
    endtask

    task automatic check_outputs(input string tag);
        ctl_t got, exp;
        got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
        exp = expect_ctl(m_state, MemReady);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, got, exp);
        end
        vectors++;
        assert (State === m_state) else begin
            miscompares++;
            $error("FAIL %s State observed=%0d expected=%0d", tag, State, m_state);
        end
        vectors++;
        assert (IllegalOp === m_ill) else begin
            miscompares++;
            $error("FAIL %s IllegalOp observed=%b expected=%b", tag, IllegalOp, m_ill);
        end
        vectors++;
        assert (MemFault === m_fault) else begin
            miscompares++;
            $error("FAIL %s MemFault observed=%b expected=%b", tag, MemFault, m_fault);
        end
    endtask

    // Drive one cycle of inputs, check, clock, advance the model.
    task automatic step(input logic rst, input logic [5:0] op, input logic rdy, input string tag);
        reset = rst; Op = op; MemReady = rdy;
        #2;
        check_outputs(tag);
        @(posedge clk);
        model_clock(rst, op, rdy);
        #1;
    endtask

    // Run one instruction from FETCH with MemReady high and check its length.
    task automatic run_instr(input logic [5:0] op, input int exp_cycles, input string tag);
        int n;
        n = 0;
        do begin
            step(1'b0, op, 1'b1, tag);
            n++;
        end while (m_state != FETCH && n < 20);
        vectors++;
        assert (n == exp_cycles) else begin
            miscompares++;
            $error("FAIL %s latency observed=%0d expected=%0d", tag, n, exp_cycles);
        end
    endtask

    task automatic check_direct(input string tag, input logic [3:0] st, input logic flt);
        vectors++;
        assert (State === st && MemFault === flt) else begin
            miscompares++;
            $error("FAIL %s State/MemFault observed=%0d/%b expected=%0d/%b",
                   tag, State, MemFault, st, flt);
        end
    endtask

    initial begin
        logic [5:0] cur_op;
        logic       rst, rdy;
        logic [5:0] ops [7];
        vectors = 0; miscompares = 0;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b111111};

        reset = 1'b1; Op = OP_LW; MemReady = 1'b0;
        @(posedge clk);
        model_clock(1'b1, OP_LW, 1'b0);
        #1;

        // Reset state: FETCH outputs, held by MemReady low
        step(1'b0, OP_LW, 1'b0, "reset_state");

        run_instr(OP_LW,   5, "lw");
        run_instr(OP_R,    4, "rtype");
        run_instr(OP_BEQ,  3, "beq");
        run_instr(OP_J,    3, "jump");
        run_instr(OP_ADDI, 4, "addi");
        run_instr(OP_SW,   4, "sw");
        run_instr(6'b111111, 2, "illegal");
        step(1'b0, 6'b111111, 1'b0, "illegal_pulse");
        step(1'b0, 6'b111111, 1'b0, "illegal_clear");
        step(1'b0, 6'b111111, 1'b1, "illegal_fetch");
        run_instr(6'b111111, 1, "illegal_again");

        // sw stalls in MEM_WR until timeout
        step(1'b0, OP_SW, 1'b1, "to_fetch");
        step(1'b0, OP_SW, 1'b1, "to_decode");
        step(1'b0, OP_SW, 1'b1, "to_addr");
        step(1'b0, OP_SW, 1'b0, "to_wait1");
        step(1'b0, OP_SW, 1'b0, "to_wait2");
        step(1'b0, OP_SW, 1'b0, "to_wait3");
        #2;
        check_direct("timeout_halt", HALT, 1'b1);
        step(1'b0, OP_SW, 1'b1, "halt_hold1");
        step(1'b0, OP_LW, 1'b1, "halt_hold2");
        step(1'b1, OP_LW, 1'b1, "halt_reset");

        // MemReady on the third wait cycle wins over the timeout
        step(1'b0, OP_SW, 1'b1, "late_fetch");
        step(1'b0, OP_SW, 1'b1, "late_decode");
        step(1'b0, OP_SW, 1'b1, "late_addr");
        step(1'b0, OP_SW, 1'b0, "late_wait1");
        step(1'b0, OP_SW, 1'b0, "late_wait2");
        step(1'b0, OP_SW, 1'b1, "late_ready");
        #2;
        check_direct("late_ready_fetch", FETCH, 1'b0);

        // Reset while in MEM_RD abandons the load
        step(1'b0, OP_LW, 1'b1, "rst_fetch");
        step(1'b0, OP_LW, 1'b1, "rst_decode");
        step(1'b0, OP_LW, 1'b1, "rst_addr");
        step(1'b1, OP_LW, 1'b0, "rst_in_memrd");
        #2;
        check_direct("rst_memrd_fetch", FETCH, 1'b0);
        vectors++;
        assert (MemRead === 1'b1 && IorD === 1'b0 && RegWrite === 1'b0) else begin
            miscompares++;
            $error("FAIL rst_memrd_outputs MemRead/IorD/RegWrite observed=%b/%b/%b expected=1/0/0",
                   MemRead, IorD, RegWrite);
        end

        // Randomized traffic: stalls, timeouts, illegal opcodes, random resets
        cur_op = OP_LW;
        for (int i = 0; i < 800; i++) begin
            if (m_state == FETCH) begin
                if ($urandom_range(0, 7) == 0)
                    cur_op = 6'($urandom_range(0, 63));
                else
                    cur_op = ops[$urandom_range(0, 6)];
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (m_state == HALT)
                rst = ($urandom_range(0, 3) == 0);
            else
                rst = ($urandom_range(0, 49) == 0);
            step(rst, cur_op, rdy, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and writeback over several clocks, sharing one ALU and one unified memory. It drives all datapath enables and mux selects, and supplies the 2-bit ALUOp consumed by the ALU control decoder. It stalls on a memory ready handshake and faults on memory timeout.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state waits for MemReady before fault; 0 disables the timeout
STATE_W, 4, width of the state register

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
Op  input  6  opcode field IR[31:26] from the instruction register
MemReady  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero (beq)
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  register write data select: 0=ALUOut, 1=MDR
IRWrite  output  1  instruction register load
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
ALUOp  output  2  00=add, 01=sub, 10=funct; goes to ALU control
ALUSrcA  output  1  0=PC, 1=rs register
ALUSrcB  output  2  00=B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
RegWrite  output  1  register file write enable
RegDst  output  1  destination register select: 0=rt, 1=rd
IllegalOp  output  1  one-cycle pulse: unsupported opcode decoded
MemFault  output  1  sticky; memory timeout occurred
State  output  STATE_W  current state, for debug

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- States and transitions:
  - FETCH -> DECODE when MemReady=1.
  - DECODE -> R: EXEC; lw/sw: MEM_ADDR; beq: BRANCH; j: JUMP; addi: ADDI_EXEC; any other opcode: FETCH.
  - EXEC -> R_WB -> FETCH.
  - MEM_ADDR -> lw: MEM_RD; sw: MEM_WR.
  - MEM_RD -> MEM_WB when MemReady=1; MEM_WB -> FETCH.
  - MEM_WR -> FETCH when MemReady=1.
  - ADDI_EXEC -> ADDI_WB -> FETCH.
  - BRANCH -> FETCH; JUMP -> FETCH.
  - HALT -> HALT, left only by reset.
- Outputs are decoded from State; in FETCH they are also gated by MemReady. Any signal not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=1 and PCWrite=1 only in the cycle MemReady=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEM_ADDR and ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEM_RD: MemRead=1, IorD=1.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEM_WR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
- IllegalOp: registered; asserts the cycle after DECODE sees an unsupported opcode, for exactly one cycle.
- Memory wait counter:
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR with MemReady=0.
  - Clears on state exit and in every other state.
  - When the count reaches MEM_TIMEOUT (nonzero), the next state is HALT and MemFault is set.
  - MemFault stays set until reset.
  - A MemReady arriving in the same cycle the count reaches MEM_TIMEOUT wins: normal transition, no fault.
- Latency with MemReady tied 1: beq/j 3 cycles, R/addi/sw 4, lw 5.
- Reset takes priority over everything in that cycle. Next state is FETCH, counter 0, MemFault 0, IllegalOp 0. Outputs then show FETCH values.
- Reset mid-instruction abandons the instruction; no RegWrite or MemWrite is issued afterwards.
- In HALT all enables are 0.

Decomposition:
- Shared package holds the opcode constants, ALUOp codes (00/01/10), PCSource and ALUSrcB encodings, and state encodings. The ALU control decoder uses the same ALUOp constants.
- One natural sub-module: mem_wait_timer, holding the counter, timeout compare and MemFault flag.

Test Plan:
- MemReady=1, Op=100011 (lw) -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; RegWrite=1 and MemtoReg=1 only in cycle 5.
- Op=000000 (R-type) -> ALUOp=10 in EXEC; RegWrite=1 with RegDst=1 in R_WB; returns to FETCH after 4 cycles.
- Op=000100 (beq) -> BRANCH has ALUOp=01, PCWriteCond=1, PCSource=01; Op=000010 (j) -> JUMP has PCWrite=1, PCSource=10.
- Op=111111 -> DECODE, then FETCH with IllegalOp=1 for exactly one cycle; RegWrite and MemWrite never assert.
- MEM_TIMEOUT=3, sw with MemReady held 0 in MEM_WR -> MemWrite held 3 cycles, then HALT with MemFault=1. MemReady=1 on the 3rd wait cycle -> FETCH, MemFault=0.
- reset=1 asserted in MEM_RD -> next cycle State=FETCH, MemFault=0, and FETCH outputs appear (MemRead=1, IorD=0).
